// File: rtl/stack_controller_pkg.sv
// Shared definitions for the stack controller.
//   OP_*      : operation codes formed as {push, pop}
//   sc_clog2  : ceiling log2, used to size the count and the RAM address
package stack_controller_pkg;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_POP     = 2'b01;
  localparam logic [1:0] OP_PUSH    = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  function automatic int sc_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stack_controller_if.sv
// Request/status bundle between the control unit and the stack controller.
//   push, pop, push_data, clear_err : requests from the control unit
//   top, SP, count, empty, full     : stack status
//   stack_overflow, stack_underflow : sticky error flags
// master = control unit side, slave = stack controller side.
interface stack_controller_if #(
  parameter int DATA_W = 10,
  parameter int SP_W   = 10,
  parameter int CNT_W  = 5
);
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              clear_err;
  logic [DATA_W-1:0] top;
  logic [SP_W-1:0]   SP;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              stack_overflow;
  logic              stack_underflow;

  modport master (
    output push, pop, push_data, clear_err,
    input  top, SP, count, empty, full, stack_overflow, stack_underflow
  );

  modport slave (
    input  push, pop, push_data, clear_err,
    output top, SP, count, empty, full, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/stack_controller_ram.sv
// Stack storage: DEPTH x DATA_W register array, not reset.
//   clk                : write clock
//   we, waddr, wdata   : synchronous write port
//   raddr, rdata       : asynchronous read port (fetches the entry below top)
module stack_controller_ram #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_controller.sv
// Hardware stack: owns the entry count, a registered copy of the top entry,
// the sticky error flags and the storage array. SP is derived from count.
//   clk    : system clock
//   reset  : synchronous, active-high; overrides any request in that cycle
//   bus    : stack_controller_if.slave (requests in, status out)
module stack_controller
  import stack_controller_pkg::*;
#(
  parameter int              DATA_W    = 10,
  parameter int              DEPTH     = 16,
  parameter int              SP_W      = 10,
  parameter logic [SP_W-1:0] SP_BASE   = 10'h3FF,
  parameter bit              GROW_DOWN = 1'b1,
  parameter int              CNT_W     = sc_clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               reset,
  stack_controller_if.slave bus
);

  localparam int AW = (sc_clog2(DEPTH) > 0) ? sc_clog2(DEPTH) : 1;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] top_q, top_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              wr_en;
  logic              ram_we;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     raddr;
  logic [DATA_W-1:0] rdata;

  logic [1:0]        op;
  logic              is_empty;
  logic              is_full;

  assign op       = {bus.push, bus.pop};
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));

  // Entry that becomes top after a pop; only meaningful when count >= 2.
  assign raddr  = AW'(count_q - CNT_W'(2));
  // Requests arriving with reset are discarded, storage included.
  assign ram_we = wr_en & ~reset;

  always_comb begin
    count_d = count_q;
    top_d   = top_q;
    ovf_d   = ovf_q & ~bus.clear_err;
    udf_d   = udf_q & ~bus.clear_err;
    wr_en   = 1'b0;
    waddr   = '0;
    case (op)
      OP_PUSH: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          waddr   = AW'(count_q);
          count_d = count_q + CNT_W'(1);
          top_d   = bus.push_data;
        end
      end
      OP_POP: begin
        if (is_empty) begin
          udf_d = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
          top_d   = (count_q >= CNT_W'(2)) ? rdata : '0;
        end
      end
      OP_REPLACE: begin
        // On an empty stack this degenerates to a push into slot 0.
        wr_en = 1'b1;
        top_d = bus.push_data;
        if (is_empty) begin
          waddr   = '0;
          count_d = CNT_W'(1);
        end else begin
          waddr = AW'(count_q - CNT_W'(1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  stack_controller_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (bus.push_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Modulo 2^SP_W arithmetic; wrap is silent.
  assign bus.SP = GROW_DOWN ? (SP_BASE - SP_W'(count_q)) : (SP_BASE + SP_W'(count_q));

  assign bus.count           = count_q;
  assign bus.top             = top_q;
  assign bus.empty           = is_empty;
  assign bus.full            = is_full;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = udf_q;

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
- Parametrised successor to the single-register stack pointer. It owns both the pointer and the stack storage.
- Supports push, pop and a same-cycle replace-top operation, with configurable width, depth, base address and growth direction.
- Reports full/empty status plus sticky overflow and underflow flags.
- Sits in the control unit and serves CALL/RET and PUSH/POP instructions. SP is still exported for debug and data-memory mirroring.

Parameters:
- DATA_W, 10, width of each stack entry
- DEPTH, 16, number of entries; must be ≥2
- SP_W, 10, width of the exported SP
- SP_BASE, 10'h3FF, SP value when the stack is empty
- GROW_DOWN, 1, 1: SP = SP_BASE − count; 0: SP = SP_BASE + count (both modulo 2^SP_W)
- CNT_W, derived = clog2(DEPTH+1), width of count

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- push  in  1  push request
- pop  in  1  pop request
- push_data  in  DATA_W  data to push or replace
- clear_err  in  1  clears the sticky error flags
- top  out  DATA_W  current top-of-stack; 0 when empty
- SP  out  SP_W  stack pointer per GROW_DOWN rule
- count  out  CNT_W  number of valid entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- stack_overflow  out  1  sticky; set by a push while full
- stack_underflow  out  1  sticky; set by a pop while empty

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-high, and has priority over every other input.
- Reset values:
  - count=0, SP=SP_BASE, top=0
  - empty=1, full=0
  - stack_overflow=0, stack_underflow=0
  - Storage contents are not reset.
- Outputs: all registered. Each operation's effect is visible exactly 1 cycle after the sampling edge.
- Operation decode (push, pop):
  - 00 NOP: nothing changes.
  - 10 PUSH:
    - not full: mem[count] ← push_data, count+1, top ← push_data.
    - full: ignored (storage, count and top unchanged); stack_overflow ← 1.
  - 01 POP:
    - not empty: count−1; top ← mem[count−2] if count ≥ 2, else 0.
    - empty: ignored; stack_underflow ← 1.
  - 11 REPLACE:
    - not empty: mem[count−1] ← push_data, count unchanged, top ← push_data. No flags change, even when full.
    - empty: behaves as PUSH; no underflow is flagged.
- SP: combinational function of the registered count, so it updates in the same cycle as count.
  - Wrap-around at 2^SP_W is modulo; no flag is raised for it.
- empty and full are derived from the registered count. They are never both 1 because DEPTH ≥ 2.
- Sticky flags:
  - Set only by the error events above.
  - Cleared by clear_err.
  - If an error event and clear_err occur in the same cycle, set wins.
- Reset mid-operation: any push or pop in the reset cycle is discarded. The next cycle shows reset values, and the first post-reset push writes mem[0].
- Illegal-condition guarantee: count never exceeds DEPTH and never goes below 0.

Decomposition:
- Shared header (stack_defs.vh) holds:
  - op encoding constants: OP_NOP=2'b00, OP_POP=2'b01, OP_PUSH=2'b10, OP_REPLACE=2'b11
  - the clog2 helper function
- One sub-module, stack_ram:
  - DEPTH×DATA_W register array
  - one synchronous write port (we, waddr, wdata)
  - one asynchronous read port (raddr, rdata), used to fetch mem[count−2] on pop
- stack_controller holds the count, top, flag registers, decode logic and SP arithmetic.

Test Plan:
(Configuration for all scenarios: DEPTH=4, DATA_W=10, SP_W=10, SP_BASE=10'h3FF, GROW_DOWN=1.)
1. Hold reset 2 cycles, then release -> count=0, SP=0x3FF, top=0, empty=1, full=0, both flags 0.
2. Push 0x011, 0x022, 0x033, 0x044 -> count=4, SP=0x3FB, top=0x044, full=1. A fifth push of 0x055 -> count=4, top=0x044, stack_overflow=1.
3. From the full state, pop ×4 -> top sequence 0x033, 0x022, 0x011, 0x000 and SP 0x3FC..0x3FF, empty=1. A fifth pop -> count=0, stack_underflow=1.
4. With stack {0x011, 0x022}, assert push+pop with push_data=0x1AB -> count=2, top=0x1AB. Next pop -> top=0x011, count=1. push+pop on an empty stack with 0x0C3 -> count=1, top=0x0C3, underflow unchanged.
5. Full stack: assert push and clear_err together -> stack_overflow stays 1. clear_err alone next cycle -> stack_overflow=0, stack_underflow=0.
6. count=3, assert reset with push=1 and push_data=0x2AA -> next cycle count=0, SP=0x3FF, top=0. A following push of 0x001 -> count=1, top=0x001.
